// File: rtl/read_data_register_pkg.sv
// -----------------------------------------------------------------------------
// read_data_register_pkg
// Shared CPU memory-interface definitions for the load (memory-to-core) path:
//   - size_e   : rd_size encodings (byte / halfword / word / reserved)
//   - state_e  : read FSM state encodings
//   - rd_ctl_t : per-access controls latched when a read is accepted
//   - CNT_W    : width of the wait-state timeout counter
// No ports (package).
// -----------------------------------------------------------------------------
package read_data_register_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11   // reserved, handled as a word access
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    size_e      size;
    logic       sign;
    logic [1:0] addr_lo;
  } rd_ctl_t;

  // Wide enough for the largest allowed timeout (65535).
  localparam int CNT_W = 16;

  // A reserved size encoding behaves exactly like a word access.
  function automatic logic is_word_size(input size_e size);
    return (size == SIZE_WORD) || (size == SIZE_RSVD);
  endfunction

endpackage

// File: rtl/read_data_register_if.sv
// -----------------------------------------------------------------------------
// read_data_register_if
// Request / memory / result signal bundle of the read data register.
//   master : core + memory side (drives request controls and memory bus)
//   slave  : read_data_register (drives result, status flags)
// Signals:
//   rd_start, rd_size[1:0], rd_signed, addr_lo[1:0] : read request
//   mem_data_in[DATA_W-1:0], mem_ready              : memory data bus
//   data_out[DATA_W-1:0], data_valid, busy, rd_error: result and status
// -----------------------------------------------------------------------------
interface read_data_register_if #(
  parameter int DATA_W = 32
);

  logic              rd_start;
  logic [1:0]        rd_size;
  logic              rd_signed;
  logic [1:0]        addr_lo;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              rd_error;

  modport master (
    output rd_start, rd_size, rd_signed, addr_lo, mem_data_in, mem_ready,
    input  data_out, data_valid, busy, rd_error
  );

  modport slave (
    input  rd_start, rd_size, rd_signed, addr_lo, mem_data_in, mem_ready,
    output data_out, data_valid, busy, rd_error
  );

endinterface

// File: rtl/read_data_extract.sv
// -----------------------------------------------------------------------------
// read_data_extract
// Purely combinational load-data formatter: selects the addressed byte or
// halfword lane of a little-endian memory word and zero/sign-extends it; word
// accesses pass the whole bus through.
// Build option: READ_ROTATE_UNALIGNED_EN -- when defined, word reads with a
// non-zero addr_lo return the bus rotated right by 8*addr_lo bits; when
// undefined, word reads always return the aligned word unrotated.
// Ports:
//   data_in[DATA_W-1:0] : raw memory data
//   size                : access size (size_e)
//   sign                : 1 = sign-extend byte/halfword
//   addr_lo[1:0]        : byte address within the word
//   result[DATA_W-1:0]  : formatted load result
// -----------------------------------------------------------------------------
module read_data_extract
  import read_data_register_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_in,
  input  size_e             size,
  input  logic              sign,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] result
);

  localparam int BI_W = $clog2(DATA_W);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] val, input logic sgn);
    return {{(DATA_W-8){sgn & val[7]}}, val};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] val, input logic sgn);
    return {{(DATA_W-16){sgn & val[15]}}, val};
  endfunction

`ifdef READ_ROTATE_UNALIGNED_EN
  localparam int SH_W = $clog2(2 * DATA_W);

  // Rotate right by whole bytes: take a window out of the doubled word.
  function automatic logic [DATA_W-1:0] rotr_bytes(input logic [DATA_W-1:0] d,
                                                   input logic [1:0] lane);
    logic [2*DATA_W-1:0] dd;
    logic [SH_W-1:0]     sh;
    dd = {d, d};
    sh = SH_W'({lane, 3'b000});
    return dd[sh +: DATA_W];
  endfunction
`endif

  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [DATA_W-1:0] word_s;

  // Lane selection and extension of the memory data
  always_comb begin
    byte_s = data_in[BI_W'({addr_lo, 3'b000}) +: 8];
    // addr_lo[0] is ignored: only aligned halfwords exist.
    half_s = data_in[BI_W'({addr_lo[1], 4'b0000}) +: 16];
`ifdef READ_ROTATE_UNALIGNED_EN
    word_s = rotr_bytes(data_in, addr_lo);
`else
    word_s = data_in;
`endif
    if (is_word_size(size)) begin
      result = word_s;
    end else begin
      case (size)
        SIZE_BYTE: result = ext_byte(byte_s, sign);
        SIZE_HALF: result = ext_half(half_s, sign);
        default:   result = word_s;
      endcase
    end
  end

endmodule

// File: rtl/read_data_register.sv
// -----------------------------------------------------------------------------
// read_data_register
// Load-side data register: on a read request it waits for memory ready,
// captures the bus through read_data_extract (lane select + extension) into
// data_out and pulses data_valid. A wait-state counter aborts a read that has
// waited TIMEOUT_CYCLES cycles, raising the sticky rd_error flag instead.
// Build option: READ_ROTATE_UNALIGNED_EN (see read_data_extract).
// Parameters:
//   DATA_W         : memory bus / result width (32)
//   TIMEOUT_CYCLES : wait cycles before a read aborts (1..65535)
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : read_data_register_if.slave (request, memory bus, result, status)
// -----------------------------------------------------------------------------
module read_data_register
  import read_data_register_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 rst_n,
  read_data_register_if.slave bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_r;
  rd_ctl_t           ctl_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic              busy_r;
  logic              rd_error_r;

  rd_ctl_t           ctl_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              timeout_s;
  logic [DATA_W-1:0] ext_s;

  // Extraction controls and timeout detection. In IDLE the live request is
  // used so a zero-wait read can capture in the same cycle it is accepted.
  always_comb begin
    if (state_r == ST_IDLE) begin
      ctl_s.size    = size_e'(bus.rd_size);
      ctl_s.sign    = bus.rd_signed;
      ctl_s.addr_lo = bus.addr_lo;
    end else begin
      ctl_s = ctl_r;
    end
    cnt_next_s = cnt_r + CNT_W'(1);
    timeout_s  = (cnt_next_s == TIMEOUT_VAL);
  end

  read_data_extract #(
    .DATA_W (DATA_W)
  ) u_extract (
    .data_in (bus.mem_data_in),
    .size    (ctl_s.size),
    .sign    (ctl_s.sign),
    .addr_lo (ctl_s.addr_lo),
    .result  (ext_s)
  );

  // Read FSM with registered status outputs and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ctl_r        <= '0;
      cnt_r        <= '0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      rd_error_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          data_valid_r <= 1'b0;
          if (bus.rd_start) begin
            ctl_r      <= ctl_s;
            cnt_r      <= '0;
            rd_error_r <= 1'b0;
            if (bus.mem_ready) begin
              data_out_r   <= ext_s;
              data_valid_r <= 1'b1;
              busy_r       <= 1'b0;
              state_r      <= ST_DONE;
            end else begin
              busy_r  <= 1'b1;
              state_r <= ST_WAIT;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          // Ready data takes priority over a timeout in the same cycle.
          if (bus.mem_ready) begin
            data_out_r   <= ext_s;
            data_valid_r <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= ST_DONE;
          end else if (timeout_s) begin
            cnt_r      <= cnt_next_s;
            rd_error_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        ST_DONE: begin
          data_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          data_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.busy       = busy_r;
  assign bus.rd_error   = rd_error_r;

endmodule

// File: tb/tb_read_data_register.sv
// -----------------------------------------------------------------------------
// tb_read_data_register
// Directed bench for read_data_register (TIMEOUT_CYCLES = 4). Each accepted
// read pushes its expected result and the cycle it must appear in onto a
// scoreboard queue; every clock step compares data_valid/data_out against it.
// -----------------------------------------------------------------------------
module tb_read_data_register;

  logic clk;
  logic rst_n;

  read_data_register_if #(.DATA_W(32)) bus ();

  read_data_register #(
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef READ_ROTATE_UNALIGNED_EN
  localparam logic [31:0] EXP_W1 = 32'h11443322;
  localparam logic [31:0] EXP_W3 = 32'h33221144;
`else
  localparam logic [31:0] EXP_W1 = 32'h44332211;
  localparam logic [31:0] EXP_W3 = 32'h44332211;
`endif

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the result stream against the scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() != 0 && cyc >= sb_q[0].due) begin
      check1("valid_due", bus.data_valid, 1'b1);
      if (bus.data_valid === 1'b1) begin
        check32("data_out", bus.data_out, sb_q[0].data);
      end
      void'(sb_q.pop_front());
    end else begin
      check1("no_spurious_valid", bus.data_valid, 1'b0);
    end
  endtask

  task automatic drive_start(input logic [1:0] size, input logic sgn, input logic [1:0] addr,
                             input logic ready, input logic [31:0] data);
    bus.rd_start    = 1'b1;
    bus.rd_size     = size;
    bus.rd_signed   = sgn;
    bus.addr_lo     = addr;
    bus.mem_ready   = ready;
    bus.mem_data_in = data;
  endtask

  task automatic idle_inputs();
    bus.rd_start  = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic push(input logic [31:0] data, input int dly);
    exp_t e;
    e.data = data;
    e.due  = cyc + dly;
    sb_q.push_back(e);
  endtask

  initial begin
    vecs[0] = '{2'b10, 1'b0, 2'b01, 32'h44332211, EXP_W1};
    vecs[1] = '{2'b10, 1'b0, 2'b11, 32'h44332211, EXP_W3};
    vecs[2] = '{2'b11, 1'b0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3] = '{2'b01, 1'b1, 2'b10, 32'h80017FFF, 32'hFFFF8001};
    vecs[4] = '{2'b01, 1'b1, 2'b00, 32'h80017FFF, 32'h00007FFF};
    vecs[5] = '{2'b01, 1'b0, 2'b11, 32'h1234ABCD, 32'h00001234};
    vecs[6] = '{2'b00, 1'b1, 2'b00, 32'h0000007F, 32'h0000007F};
    vecs[7] = '{2'b00, 1'b0, 2'b10, 32'h00C30000, 32'h000000C3};
    vecs[8] = '{2'b00, 1'b1, 2'b01, 32'h0000C300, 32'hFFFFFFC3};

    rst_n           = 1'b0;
    bus.rd_start    = 1'b0;
    bus.rd_size     = 2'b00;
    bus.rd_signed   = 1'b0;
    bus.addr_lo     = 2'b00;
    bus.mem_data_in = 32'h0;
    bus.mem_ready   = 1'b0;
    #12;
    check32("rst_data_out", bus.data_out, 32'h0);
    check1("rst_data_valid", bus.data_valid, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_rd_error", bus.rd_error, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Signed byte, zero wait states.
    drive_start(2'b00, 1'b1, 2'b11, 1'b1, 32'h80FF1234);
    push(32'hFFFFFF80, 1);
    step();
    idle_inputs();
    check1("t1_rd_error", bus.rd_error, 1'b0);
    check1("t1_busy_done", bus.busy, 1'b0);
    step();

    // Unsigned halfword, four WAIT cycles (ready low for three of them).
    drive_start(2'b01, 1'b0, 2'b10, 1'b0, 32'hBEEF0001);
    push(32'h0000BEEF, 5);
    step();
    bus.rd_start = 1'b0;
    check1("t2_busy_w1", bus.busy, 1'b1);
    step();
    check1("t2_busy_w2", bus.busy, 1'b1);
    step();
    check1("t2_busy_w3", bus.busy, 1'b1);
    step();
    check1("t2_busy_w4", bus.busy, 1'b1);
    bus.mem_ready = 1'b1;
    step();
    check1("t2_busy_done", bus.busy, 1'b0);
    idle_inputs();
    step();

    // Timeout after four wait cycles; data_out keeps the previous result.
    drive_start(2'b10, 1'b0, 2'b00, 1'b0, 32'h12345678);
    step();
    bus.rd_start = 1'b0;
    step();
    step();
    step();
    check1("t3_busy_last_wait", bus.busy, 1'b1);
    check1("t3_no_error_yet", bus.rd_error, 1'b0);
    step();
    check1("t3_rd_error", bus.rd_error, 1'b1);
    check1("t3_busy_idle", bus.busy, 1'b0);
    check32("t3_data_kept", bus.data_out, 32'h0000BEEF);
    step();
    step();
    check1("t3_error_sticky", bus.rd_error, 1'b1);
    drive_start(2'b00, 1'b0, 2'b01, 1'b1, 32'h0000AB00);
    push(32'h000000AB, 1);
    step();
    idle_inputs();
    check1("t3_error_cleared", bus.rd_error, 1'b0);
    step();

    // Lane / extension / word-rotation table, zero wait states.
    for (int i = 0; i < 9; i++) begin
      drive_start(vecs[i].size, vecs[i].sgn, vecs[i].addr, 1'b1, vecs[i].data);
      push(vecs[i].exp, 1);
      step();
      idle_inputs();
      step();
    end

    // rd_start while waiting must not change the latched controls.
    drive_start(2'b01, 1'b0, 2'b00, 1'b0, 32'h80FFF00F);
    push(32'h0000F00F, 3);
    step();
    drive_start(2'b00, 1'b1, 2'b11, 1'b0, 32'h80FFF00F);
    step();
    bus.rd_start = 1'b0;
    check1("t5_busy_after_ignored", bus.busy, 1'b1);
    bus.mem_ready = 1'b1;
    step();
    idle_inputs();
    step();

    // Reset asserted mid-read clears everything at once; no data_valid after.
    drive_start(2'b10, 1'b0, 2'b00, 1'b0, 32'hCAFEF00D);
    step();
    bus.rd_start = 1'b0;
    check1("t6_busy_wait", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check32("t6_rst_data_out", bus.data_out, 32'h0);
    check1("t6_rst_busy", bus.busy, 1'b0);
    check1("t6_rst_valid", bus.data_valid, 1'b0);
    check1("t6_rst_error", bus.rd_error, 1'b0);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();
    step();
    check32("t6_data_after_rst", bus.data_out, 32'h0);
    check1("t6_busy_after_rst", bus.busy, 1'b0);

    check1("scoreboard_drained", (sb_q.size() == 0), 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
